// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data RAM between the CPU load/store stage (port 0)
// and the debug/loader master (port 1), with starvation escape and DBG lock bursts.
//
// state    | meaning
// CPU_PRI  | CPU wins contention; DBG served when CPU idle, starve_cnt tracks denials
// DBG_PRI  | DBG was starved MAX_WAIT cycles; DBG wins this cycle if still requesting
// DBG_LOCK | DBG owns the RAM exclusively; CPU stalls until dbg_lock drops
module dmem_port_arbiter #(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   input  logic              dbg_lock,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

   typedef enum logic [1:0] {
      CPU_PRI  = 2'd0,
      DBG_PRI  = 2'd1,
      DBG_LOCK = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] starve_nxt;
   logic             cpu_rd_q;
   logic             dbg_rd_q;

   // Grants are suppressed while rst is high so nothing reaches the RAM during reset.
   always_comb begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
      if (!rst) begin
         case (state)
            CPU_PRI: begin
               cpu_gnt = cpu_req;
               dbg_gnt = dbg_req & ~cpu_req;
            end
            DBG_PRI: begin
               dbg_gnt = dbg_req;
               cpu_gnt = cpu_req & ~dbg_req;
            end
            DBG_LOCK: dbg_gnt = dbg_req;
            default: ;
         endcase
      end
   end

   always_comb begin
      starve_nxt = starve_cnt;
      if (dbg_gnt || !dbg_req)
         starve_nxt = '0;
      else if (state == CPU_PRI && starve_cnt != CNT_MAX)
         starve_nxt = starve_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= CPU_PRI;
         starve_cnt <= '0;
         cpu_rd_q   <= 1'b0;
         dbg_rd_q   <= 1'b0;
      end else begin
         cpu_rd_q   <= cpu_gnt & ~cpu_we;
         dbg_rd_q   <= dbg_gnt & ~dbg_we;
         starve_cnt <= starve_nxt;
         case (state)
            CPU_PRI: begin
               if (dbg_gnt && dbg_lock)
                  state <= DBG_LOCK;
               else if (starve_nxt == CNT_MAX)
                  state <= DBG_PRI;
            end
            DBG_PRI: begin
               if (dbg_gnt && dbg_lock)
                  state <= DBG_LOCK;
               else
                  state <= CPU_PRI;
            end
            DBG_LOCK: begin
               if (!dbg_lock)
                  state <= CPU_PRI;
            end
            default: state <= CPU_PRI;
         endcase
      end
   end

   // rvalid is masked by rst so a read in flight when reset hits never surfaces.
   assign cpu_rvalid = cpu_rd_q & ~rst;
   assign dbg_rvalid = dbg_rd_q & ~rst;
   assign cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
   assign dbg_rdata  = dbg_rvalid ? ram_rdata : '0;
   assign cpu_stall  = cpu_req & ~cpu_gnt;

   assign ram_en    = cpu_gnt | dbg_gnt;
   assign ram_we    = cpu_gnt ? cpu_we : (dbg_gnt & dbg_we);
   assign ram_addr  = dbg_gnt ? dbg_addr : cpu_addr;
   assign ram_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed scenarios plus randomized traffic
// checked against a priority/lock/starvation model and a shadow memory.
module tb_dmem_port_arbiter;

   localparam int ADDR_W   = 6;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              cpu_req, cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt, cpu_rvalid, cpu_stall;
   logic [DATA_W-1:0] cpu_rdata;
   logic              dbg_req, dbg_we, dbg_lock;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_gnt, dbg_rvalid;
   logic [DATA_W-1:0] dbg_rdata;
   logic              ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata = '0;

   dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural RAM; cleared on its first clock (rst is high then, so no access competes).
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < (1<<ADDR_W); i++) mem[i] <= '0;
         mem_ready <= 1'b1;
      end else if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   typedef struct packed {
      logic              cg, dg, en, we, stall;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wd;
      logic              crv;
      logic [DATA_W-1:0] crd;
      logic              drv;
      logic [DATA_W-1:0] drd;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: ownership rules expressed as flags and a denial count.
   logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
   logic m_locked, m_owed;
   int   m_denied;
   logic p_c, p_d;
   logic [DATA_W-1:0] p_cdata, p_ddata;
   logic last_cg, last_dg;

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("cpu_gnt",    32'(cpu_gnt),    32'(e.cg));
         chk("dbg_gnt",    32'(dbg_gnt),    32'(e.dg));
         chk("ram_en",     32'(ram_en),     32'(e.en));
         chk("ram_we",     32'(ram_we),     32'(e.we));
         chk("cpu_stall",  32'(cpu_stall),  32'(e.stall));
         chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e.crv));
         chk("cpu_rdata",  cpu_rdata,       e.crd);
         chk("dbg_rvalid", 32'(dbg_rvalid), 32'(e.drv));
         chk("dbg_rdata",  dbg_rdata,       e.drd);
         chk("one_rvalid", 32'(cpu_rvalid & dbg_rvalid), 32'd0);
         if (e.en) begin
            chk("ram_addr", 32'(ram_addr), 32'(e.addr));
            if (e.we) chk("ram_wdata", ram_wdata, e.wd);
         end
      end
   end

   task automatic cycle(input logic r, input logic cr, input logic cw, input logic [ADDR_W-1:0] ca,
                        input logic [DATA_W-1:0] cd, input logic dr, input logic dw,
                        input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd, input logic dl);
      exp_t e;
      logic gc, gd;
      @(posedge clk); #1;
      rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd; dbg_lock = dl;
      e = '0;
      gc = 1'b0;
      gd = 1'b0;
      if (!r) begin
         e.crv = p_c;
         e.crd = p_c ? p_cdata : '0;
         e.drv = p_d;
         e.drd = p_d ? p_ddata : '0;
         if (m_locked) gd = dr;
         else if (m_owed) begin gd = dr; gc = cr & ~dr; end
         else begin gc = cr; gd = dr & ~cr; end
      end
      e.cg = gc; e.dg = gd; e.en = gc | gd;
      e.we = gc ? cw : (gd & dw);
      e.addr = gc ? ca : da;
      e.wd = gc ? cd : dd;
      e.stall = cr & ~gc;
      exp_q.push_back(e);
      if (r) begin
         m_locked = 1'b0; m_owed = 1'b0; m_denied = 0; p_c = 1'b0; p_d = 1'b0;
      end else begin
         p_c = gc & ~cw; p_cdata = ref_mem[ca];
         p_d = gd & ~dw; p_ddata = ref_mem[da];
         if (gc && cw) ref_mem[ca] = cd;
         if (gd && dw) ref_mem[da] = dd;
         m_locked = m_locked ? dl : (gd & dl);
         if (gd || !dr) begin
            m_denied = 0; m_owed = 1'b0;
         end else begin
            if (m_denied < MAX_WAIT) m_denied++;
            m_owed = (m_denied == MAX_WAIT);
         end
      end
      last_cg = gc;
      last_dg = gd;
   endtask

   logic              c_req, c_we, d_req, d_we, d_lock, r_rst, hold_c, hold_d;
   logic [ADDR_W-1:0] c_addr, d_addr;
   logic [DATA_W-1:0] c_wd, d_wd;

   initial begin
      rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
      for (int i = 0; i < (1<<ADDR_W); i++) ref_mem[i] = '0;
      m_locked = 0; m_owed = 0; m_denied = 0; p_c = 0; p_d = 0;
      p_cdata = '0; p_ddata = '0; last_cg = 0; last_dg = 0;

      // reset with both requests high, then first grant to CPU
      for (int i = 0; i < 5; i++) cycle(1, 1, 0, 6'd0, 0, 1, 0, 6'd1, 0, 0);
      cycle(0, 1, 0, 6'd0, 0, 1, 0, 6'd1, 0, 0);
      cycle(0, 0, 0, 6'd0, 0, 0, 0, 6'd0, 0, 0);
      // CPU store then load
      cycle(0, 1, 1, 6'd12, 32'hDEADBEEF, 0, 0, 6'd0, 0, 0);
      cycle(0, 1, 0, 6'd12, 0, 0, 0, 6'd0, 0, 0);
      cycle(0, 0, 0, 6'd0, 0, 0, 0, 6'd0, 0, 0);
      // sustained contention: starvation escape every MAX_WAIT+1 cycles
      for (int i = 0; i < 15; i++) cycle(0, 1, 0, 6'd12, 0, 1, 0, 6'd2, 0, 0);
      cycle(0, 0, 0, 6'd0, 0, 0, 0, 6'd0, 0, 0);
      // lock burst: DBG writes 1..8 to addrs 0..7 while CPU waits
      cycle(0, 0, 0, 6'd0, 0, 1, 1, 6'd0, 32'd1, 1);
      for (int i = 1; i < 8; i++) cycle(0, 1, 0, 6'd7, 0, 1, 1, 6'(i), 32'(i + 1), 1);
      cycle(0, 1, 0, 6'd7, 0, 0, 0, 6'd0, 0, 0);
      cycle(0, 1, 0, 6'd7, 0, 0, 0, 6'd0, 0, 0);
      cycle(0, 0, 0, 6'd0, 0, 0, 0, 6'd0, 0, 0);
      // interleaved reads
      cycle(0, 0, 0, 6'd0, 0, 1, 0, 6'd3, 0, 0);
      cycle(0, 1, 0, 6'd5, 0, 0, 0, 6'd0, 0, 0);
      cycle(0, 0, 0, 6'd0, 0, 0, 0, 6'd0, 0, 0);
      // reset one cycle after a CPU read grant
      cycle(0, 1, 0, 6'd4, 0, 0, 0, 6'd0, 0, 0);
      cycle(1, 0, 0, 6'd0, 0, 0, 0, 6'd0, 0, 0);
      cycle(0, 0, 0, 6'd0, 0, 1, 0, 6'd4, 0, 0);
      cycle(0, 0, 0, 6'd0, 0, 0, 0, 6'd0, 0, 0);

      // randomized traffic honouring the hold-until-grant rule
      hold_c = 0; hold_d = 0;
      c_req = 0; c_we = 0; c_addr = '0; c_wd = '0;
      d_req = 0; d_we = 0; d_addr = '0; d_wd = '0; d_lock = 0;
      for (int n = 0; n < 3000; n++) begin
         r_rst = ($urandom % 97) == 0;
         if (!hold_c) begin
            c_req = ($urandom % 4) != 0; c_we = $urandom % 2;
            c_addr = 6'($urandom_range(0, 15)); c_wd = $urandom;
         end
         if (!hold_d) begin
            d_req = ($urandom % 3) != 0; d_we = $urandom % 2;
            d_addr = 6'($urandom_range(0, 15)); d_wd = $urandom;
         end
         if (($urandom % 10) == 0) d_lock = ~d_lock;
         cycle(r_rst, c_req, c_we, c_addr, c_wd, d_req, d_we, d_addr, d_wd, d_lock);
         hold_c = c_req & ~last_cg;
         hold_d = d_req & ~last_dg;
      end

      cycle(0, 0, 0, 6'd0, 0, 0, 0, 6'd0, 0, 0);
      cycle(0, 0, 0, 6'd0, 0, 0, 0, 6'd0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
